// File: rtl/ex_branch_rs_pkg.sv
// Shared types, tag constants and op codes for the branch reservation queue.
package ex_branch_rs_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned TAG_W_DEF = 4;

   typedef logic [XLEN_DEF-1:0]  word_t;
   typedef logic [XLEN_DEF-1:0]  addr_t;
   typedef logic [TAG_W_DEF-1:0] regtag_t;
   typedef logic [3:0]           sinst_t;

   localparam regtag_t UNLOCKED = '1;
   localparam word_t   ZERO     = '0;

   localparam sinst_t BEQ  = 4'd1;
   localparam sinst_t BNE  = 4'd2;
   localparam sinst_t BLT  = 4'd3;
   localparam sinst_t BGE  = 4'd4;
   localparam sinst_t BLTU = 4'd5;
   localparam sinst_t BGEU = 4'd6;
   localparam sinst_t JAL  = 4'd7;
   localparam sinst_t JALR = 4'd8;

   function automatic logic op_known(input sinst_t op);
      return (op >= BEQ) && (op <= JALR);
   endfunction

endpackage

// File: rtl/ex_branch_rs_branch_cmp.sv
// Combinational branch resolver: compare outcome, next PC and jump flag for one op.
module branch_cmp
   import ex_branch_rs_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  sinst_t          op,
   input  logic [XLEN-1:0] datax,
   input  logic [XLEN-1:0] datay,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] offset,
   output logic            taken,
   output logic [XLEN-1:0] dest,
   output logic            is_jump
);

   logic [XLEN-1:0] jump;
   logic [XLEN-1:0] remain;
   logic [XLEN-1:0] indirect;

   assign jump     = pc + offset;
   assign remain   = pc + XLEN'(4);
   assign indirect = (datax + offset) & ~XLEN'(1);

   always_comb begin
      taken   = 1'b0;
      is_jump = 1'b0;
      case (op)
         BEQ:  taken = (datax == datay);
         BNE:  taken = (datax != datay);
         BLT:  taken = ($signed(datax) < $signed(datay));
         BGE:  taken = ($signed(datax) >= $signed(datay));
         BLTU: taken = (datax < datay);
         BGEU: taken = (datax >= datay);
         JAL, JALR: begin
            taken   = 1'b1;
            is_jump = 1'b1;
         end
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      if (op == JALR) dest = indirect;
      else if (taken) dest = jump;
      else            dest = remain;
   end

endmodule

// File: rtl/ex_branch_rs.sv
// In-order branch reservation queue: CDB operand capture, head-only resolution,
// registered target/mispredict/link outputs and self-squash on mispredict.
module ex_branch_rs
   import ex_branch_rs_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             flush,
   input  logic             alloc_valid,
   output logic             alloc_ready,
   input  sinst_t           alloc_op,
   input  logic [XLEN-1:0]  alloc_pc,
   input  logic [XLEN-1:0]  alloc_offset,
   input  logic             alloc_pred_taken,
   input  logic [TAG_W-1:0] alloc_tagx,
   input  logic [TAG_W-1:0] alloc_tagy,
   input  logic [XLEN-1:0]  alloc_datax,
   input  logic [XLEN-1:0]  alloc_datay,
   input  logic [TAG_W-1:0] alloc_rd_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]  cdb_data,
   output logic             en,
   output logic [XLEN-1:0]  dest_out,
   output logic             mispredict,
   output logic             wb_valid,
   output logic [TAG_W-1:0] wb_tag,
   output logic [XLEN-1:0]  wb_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [TAG_W-1:0] UNL = {TAG_W{1'b1}};

   sinst_t           op_q    [DEPTH];
   logic [XLEN-1:0]  pc_q    [DEPTH];
   logic [XLEN-1:0]  off_q   [DEPTH];
   logic             pred_q  [DEPTH];
   logic [TAG_W-1:0] tagx_q  [DEPTH];
   logic [TAG_W-1:0] tagy_q  [DEPTH];
   logic [XLEN-1:0]  datax_q [DEPTH];
   logic [XLEN-1:0]  datay_q [DEPTH];
   logic [TAG_W-1:0] rd_q    [DEPTH];

   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;

   logic            head_ready, resolve, squash, accept, cdb_hit;
   logic            head_taken, head_is_jump, head_mis;
   logic [XLEN-1:0] head_dest;

   branch_cmp #(
      .XLEN (XLEN)
   ) u_cmp (
      .op      (op_q[head_q]),
      .datax   (datax_q[head_q]),
      .datay   (datay_q[head_q]),
      .pc      (pc_q[head_q]),
      .offset  (off_q[head_q]),
      .taken   (head_taken),
      .dest    (head_dest),
      .is_jump (head_is_jump)
   );

   assign alloc_ready = (count_q != CNT_W'(DEPTH));
   assign head_ready  = (count_q != '0) && (tagx_q[head_q] == UNL) && (tagy_q[head_q] == UNL);
   assign resolve     = head_ready && op_known(op_q[head_q]);
   // Indirect targets are never predicted, so JALR always redirects the front end.
   assign head_mis    = (op_q[head_q] == JALR) || (head_taken != pred_q[head_q]);
   assign squash      = resolve && head_mis;
   assign accept      = alloc_valid && alloc_ready;
   assign cdb_hit     = cdb_valid && (cdb_tag != UNL);

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         en         <= 1'b0;
         dest_out   <= '0;
         mispredict <= 1'b0;
         wb_valid   <= 1'b0;
         wb_tag     <= '0;
         wb_data    <= '0;
      end else if (rdy) begin
         if (flush) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            en         <= 1'b0;
            dest_out   <= '0;
            mispredict <= 1'b0;
            wb_valid   <= 1'b0;
            wb_tag     <= '0;
            wb_data    <= '0;
         end else begin
            en         <= resolve;
            dest_out   <= resolve ? head_dest : '0;
            mispredict <= squash;
            wb_valid   <= resolve && head_is_jump;
            wb_tag     <= (resolve && head_is_jump) ? rd_q[head_q] : '0;
            wb_data    <= (resolve && head_is_jump) ? pc_q[head_q] + XLEN'(4) : '0;

            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (cdb_hit && (tagx_q[i] == cdb_tag)) begin
                  tagx_q[i]  <= UNL;
                  datax_q[i] <= cdb_data;
               end
               if (cdb_hit && (tagy_q[i] == cdb_tag)) begin
                  tagy_q[i]  <= UNL;
                  datay_q[i] <= cdb_data;
               end
            end

            if (squash) begin
               head_q  <= '0;
               tail_q  <= '0;
               count_q <= '0;
            end else begin
               if (head_ready) head_q <= head_q + PTR_W'(1);
               if (accept) begin
                  // Written after the snoop loop so the bypassed values win for this slot.
                  op_q[tail_q]    <= alloc_op;
                  pc_q[tail_q]    <= alloc_pc;
                  off_q[tail_q]   <= alloc_offset;
                  pred_q[tail_q]  <= alloc_pred_taken;
                  rd_q[tail_q]    <= alloc_rd_tag;
                  tagx_q[tail_q]  <= (cdb_hit && alloc_tagx == cdb_tag) ? UNL : alloc_tagx;
                  datax_q[tail_q] <= (cdb_hit && alloc_tagx == cdb_tag) ? cdb_data : alloc_datax;
                  tagy_q[tail_q]  <= (cdb_hit && alloc_tagy == cdb_tag) ? UNL : alloc_tagy;
                  datay_q[tail_q] <= (cdb_hit && alloc_tagy == cdb_tag) ? cdb_data : alloc_datay;
                  tail_q          <= tail_q + PTR_W'(1);
               end
               count_q <= count_q + CNT_W'(accept) - CNT_W'(head_ready);
            end
         end
      end
   end

endmodule
